// File: rtl/gauss3x3_window.sv
// gauss3x3_window: builds a 3x3 window from streamed 3-row pixel columns and
// applies the Gaussian kernel [1 2 1; 2 4 2; 1 2 1]/16, emitting only
// valid-convolution pixels with a fixed 3-cycle latency.
// Optional macro GAUSS_ROUND_EN: round half up on the final divide by 16
// (default build truncates).
module gauss3x3_window #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 1024,
  parameter int IMG_HEIGHT = 768
) (
  input  logic                    in_clk,
  input  logic                    rst_n,
  input  logic                    in_vs,
  input  logic                    in_de,
  input  logic [3*DATA_WIDTH-1:0] in_col,
  output logic                    out_de,
  output logic [DATA_WIDTH-1:0]   out_data
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int V_W   = DATA_WIDTH + 2;
  localparam int S_W   = DATA_WIDTH + 4;
  localparam int CW    = 3 * DATA_WIDTH;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  // Position counters
  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic [COL_W-1:0] eff_col;
  logic [ROW_W-1:0] eff_row;
  logic             win_ok;

  // Stage 1: window columns (left = oldest, right = newest)
  logic [CW-1:0] col_l_q, col_l_d;
  logic [CW-1:0] col_c_q, col_c_d;
  logic [CW-1:0] col_r_q, col_r_d;
  logic          de_p1_q, de_p1_d;

  // Stage 2: vertical sums per window column
  logic [V_W-1:0] v_l_q, v_l_d;
  logic [V_W-1:0] v_c_q, v_c_d;
  logic [V_W-1:0] v_r_q, v_r_d;
  logic           de_p2_q, de_p2_d;

  // Stage 3: horizontal sum and normalisation
  logic [S_W-1:0]        sum_s;
  logic [S_W-1:0]        sum_r;
  logic                  out_de_q, out_de_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  unused_sum_lsbs;

  // top + 2*mid + bot for one packed column; the result cannot overflow V_W bits
  function automatic logic [V_W-1:0] vsum(input logic [CW-1:0] col);
    logic [V_W-1:0] top;
    logic [V_W-1:0] mid;
    logic [V_W-1:0] bot;
    top = {2'b00, col[3*DATA_WIDTH-1:2*DATA_WIDTH]};
    mid = {1'b0, col[2*DATA_WIDTH-1:DATA_WIDTH], 1'b0};
    bot = {2'b00, col[DATA_WIDTH-1:0]};
    return top + mid + bot;
  endfunction

  // Column/row tracking; a frame-start pulse makes the current column count as (0,0)
  always_comb begin
    eff_col   = col_cnt_q;
    eff_row   = row_cnt_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (in_vs) begin
      eff_col   = '0;
      eff_row   = '0;
      col_cnt_d = '0;
      row_cnt_d = '0;
    end
    if (in_de) begin
      if (eff_col == COL_LAST) begin
        col_cnt_d = '0;
        row_cnt_d = (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
      end else begin
        col_cnt_d = eff_col + COL_W'(1);
      end
    end
    win_ok = (eff_col >= COL_TWO) && (eff_row >= ROW_TWO);
  end

  // Shift the window one column left on every valid input column
  always_comb begin
    col_l_d = col_l_q;
    col_c_d = col_c_q;
    col_r_d = col_r_q;
    de_p1_d = in_de & win_ok;
    if (in_de) begin
      col_l_d = col_c_q;
      col_c_d = col_r_q;
      col_r_d = in_col;
    end
  end

  // Vertical weighting of each window column, captured only for a completed window
  always_comb begin
    v_l_d   = v_l_q;
    v_c_d   = v_c_q;
    v_r_d   = v_r_q;
    de_p2_d = de_p1_q;
    if (de_p1_q) begin
      v_l_d = vsum(col_l_q);
      v_c_d = vsum(col_c_q);
      v_r_d = vsum(col_r_q);
    end
  end

  // Horizontal weighting and divide by 16; output data holds between valid pulses
  always_comb begin
    sum_s = {2'b00, v_l_q} + {1'b0, v_c_q, 1'b0} + {2'b00, v_r_q};
`ifdef GAUSS_ROUND_EN
    sum_r = sum_s + S_W'(8);
`else
    sum_r = sum_s;
`endif
    unused_sum_lsbs = ^sum_r[3:0];
    out_de_d        = de_p2_q;
    out_data_d      = out_data_q;
    if (de_p2_q) begin
      out_data_d = sum_r[S_W-1:4];
    end
  end

  // All state registers; reset clears position, window, pipeline and outputs
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
      col_l_q    <= '0;
      col_c_q    <= '0;
      col_r_q    <= '0;
      de_p1_q    <= 1'b0;
      v_l_q      <= '0;
      v_c_q      <= '0;
      v_r_q      <= '0;
      de_p2_q    <= 1'b0;
      out_de_q   <= 1'b0;
      out_data_q <= '0;
    end else begin
      col_cnt_q  <= col_cnt_d;
      row_cnt_q  <= row_cnt_d;
      col_l_q    <= col_l_d;
      col_c_q    <= col_c_d;
      col_r_q    <= col_r_d;
      de_p1_q    <= de_p1_d;
      v_l_q      <= v_l_d;
      v_c_q      <= v_c_d;
      v_r_q      <= v_r_d;
      de_p2_q    <= de_p2_d;
      out_de_q   <= out_de_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_de   = out_de_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_gauss3x3_window.sv
// tb_gauss3x3_window: directed frames against a 2-D convolution model of the
// Gaussian window filter, plus hand-computed literal checks.
module tb_gauss3x3_window;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int IH = 6;

`ifdef GAUSS_ROUND_EN
  localparam int RND = 8;
  localparam int IMP_C = 64;
  localparam int IMP_E = 32;
  localparam int IMP_D = 16;
`else
  localparam int RND = 0;
  localparam int IMP_C = 63;
  localparam int IMP_E = 31;
  localparam int IMP_D = 15;
`endif

  logic          in_clk = 1'b0;
  logic          rst_n  = 1'b1;
  logic          in_vs  = 1'b0;
  logic          in_de  = 1'b0;
  logic [3*DW-1:0] in_col = '0;
  logic          out_de;
  logic [DW-1:0] out_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int due;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   obs[$];
  int   m_col = 0;
  int   m_row = 0;
  int   win[3][3];
  int   m_ec;
  int   m_er;
  int   m_s;

  always #5 in_clk = ~in_clk;

  gauss3x3_window #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (IW),
    .IMG_HEIGHT(IH)
  ) dut (
    .in_clk  (in_clk),
    .rst_n   (rst_n),
    .in_vs   (in_vs),
    .in_de   (in_de),
    .in_col  (in_col),
    .out_de  (out_de),
    .out_data(out_data)
  );

  // Record one comparison and report it when it does not hold
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge
  task automatic applyStimulus(input logic vs, input logic de, input logic [3*DW-1:0] col);
    @(posedge in_clk);
    #1;
    in_vs  = vs;
    in_de  = de;
    in_col = col;
  endtask

  function automatic int kw(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic int pix(input int kind, input int x, input int y);
    if (y < 0) return 0;
    case (kind)
      0:       return 100;
      1:       return (x == 4 && y == 3) ? 255 : 0;
      2:       return 255;
      3:       return (x * 17 + y * 29) & 255;
      default: return ((x * 37) ^ (y * 91) ^ 90) & 255;
    endcase
  endfunction

  function automatic logic [3*DW-1:0] column(input int kind, input int x, input int y);
    logic [3*DW-1:0] c;
    c[3*DW-1:2*DW] = DW'(pix(kind, x, y - 2));
    c[2*DW-1:DW]   = DW'(pix(kind, x, y - 1));
    c[DW-1:0]      = DW'(pix(kind, x, y));
    return c;
  endfunction

  // Stream columns of a frame up to (not including) linear index stop_at.
  // vs_mode: 0 no frame start, 1 separate pulse first, 2 pulse with first column.
  task automatic sendFrame(input int kind, input int gap, input int vs_mode, input int stop_at);
    if (vs_mode == 1) applyStimulus(1'b1, 1'b0, '0);
    for (int idx = 0; idx < stop_at; idx++) begin
      applyStimulus((vs_mode == 2 && idx == 0), 1'b1, column(kind, idx % IW, idx / IW));
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, '0);
    end
  endtask

  task automatic drainAndCheck(input string name, input int pulses);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, '0);
    checkOutput({name, " pending"}, exp_q.size(), 0);
    checkOutput({name, " pulses"}, obs.size(), pulses);
  endtask

  // Reference model: tracks position by the frame rules and convolves the last three columns
  always @(posedge in_clk) begin
    cyc++;
    if (rst_n) begin
      m_ec = in_vs ? 0 : m_col;
      m_er = in_vs ? 0 : m_row;
      if (in_de) begin
        for (int i = 0; i < 3; i++) begin
          win[0][i] = win[1][i];
          win[1][i] = win[2][i];
        end
        win[2][0] = int'(in_col[3*DW-1:2*DW]);
        win[2][1] = int'(in_col[2*DW-1:DW]);
        win[2][2] = int'(in_col[DW-1:0]);
        if (m_ec >= 2 && m_er >= 2) begin
          m_s = RND;
          for (int j = 0; j < 3; j++)
            for (int i = 0; i < 3; i++)
              m_s += kw(j) * kw(i) * win[j][i];
          exp_q.push_back('{cyc + 2, m_s / 16});
        end
        if (m_ec == IW - 1) begin
          m_col = 0;
          m_row = (m_er == IH - 1) ? 0 : m_er + 1;
        end else begin
          m_col = m_ec + 1;
          m_row = m_er;
        end
      end else if (in_vs) begin
        m_col = 0;
        m_row = 0;
      end
    end
  end

  // Reset discards anything in flight and restarts the position
  always @(negedge rst_n) begin
    exp_q.delete();
    m_col = 0;
    m_row = 0;
  end

  // Compare outputs against the model every cycle on the falling edge
  always @(negedge in_clk) begin
    if (!rst_n) begin
      checkOutput("reset out_de", out_de, 0);
      checkOutput("reset out_data", out_data, 0);
    end else begin
      if (out_de === 1'b1) obs.push_back(int'(out_data));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        checkOutput("out_de", out_de, 1);
        checkOutput("out_data", out_data, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        checkOutput("out_de idle", out_de, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0);
    #2 rst_n = 1'b1;

    $display("[TB] flat 100, continuous");
    obs.delete();
    sendFrame(0, 0, 1, IW * IH);
    drainAndCheck("flat100", 24);
    checkOutput("flat100 first", obs[0], 100);

    $display("[TB] impulse");
    obs.delete();
    sendFrame(1, 0, 1, IW * IH);
    drainAndCheck("impulse", 24);
    checkOutput("impulse centre", obs[15], IMP_C);
    checkOutput("impulse left", obs[14], IMP_E);
    checkOutput("impulse right", obs[16], IMP_E);
    checkOutput("impulse up", obs[9], IMP_E);
    checkOutput("impulse down", obs[21], IMP_E);
    checkOutput("impulse diag ul", obs[8], IMP_D);
    checkOutput("impulse diag dr", obs[22], IMP_D);
    checkOutput("impulse far", obs[0], 0);
    checkOutput("impulse far2", obs[23], 0);

    $display("[TB] flat 255");
    obs.delete();
    sendFrame(2, 0, 1, IW * IH);
    drainAndCheck("flat255", 24);
    checkOutput("flat255 first", obs[0], 255);
    checkOutput("flat255 last", obs[23], 255);

    $display("[TB] flat 100, gapped 1-0-0");
    obs.delete();
    sendFrame(0, 2, 1, IW * IH);
    drainAndCheck("gapped", 24);

    $display("[TB] frame restart at col 5 row 3");
    obs.delete();
    sendFrame(3, 0, 1, 3 * IW + 5);
    sendFrame(3, 0, 2, IW * IH);
    drainAndCheck("restart", 33);
    checkOutput("restart first", obs[0], 46);

    $display("[TB] reset mid-row");
    obs.delete();
    sendFrame(4, 0, 1, 3 * IW + 6);
    @(posedge in_clk);
    #2;
    checkOutput("pre-reset out_de", out_de, 1);
    #1;
    rst_n = 1'b0;
    in_de = 1'b0;
    in_vs = 1'b0;
    #1;
    checkOutput("async out_de", out_de, 0);
    checkOutput("async out_data", out_data, 0);
    @(posedge in_clk);
    #3 rst_n = 1'b1;
    sendFrame(4, 0, 0, IW * IH);
    drainAndCheck("post-reset", 31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
